uart_rx_oversampled: RTL and testbench



---
 rtl/uart_rx_oversampled_if.sv | 31 +++
 rtl/uart_rx_oversampled.sv | 154 +++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_oversampled_if.sv
// Receive-side byte stream of the UART: ready/valid byte handshake plus the
// one-cycle error pulses that the MMIO status register captures.
//   data_out        received byte, held stable while data_out_valid is high
//   data_out_valid  data_out holds an unconsumed byte
//   data_out_ready  consumer accepts the byte this cycle
//   frame_error     one-cycle pulse, stop bit sampled low
//   overrun         one-cycle pulse, completed byte dropped (buffer full)
// master: the receiver; slave: the MMIO read path.
interface uart_rx_oversampled_if;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;
  logic       frame_error;
  logic       overrun;

  modport master (
    output data_out,
    output data_out_valid,
    output frame_error,
    output overrun,
    input  data_out_ready
  );

  modport slave (
    input  data_out,
    input  data_out_valid,
    input  frame_error,
    input  overrun,
    output data_out_ready
  );
endinterface

// File: rtl/uart_rx_oversampled.sv
// UART receive front end: 8N1, LSB first, oversampled at the core clock.
// Each bit is decided by a 2-of-3 majority vote taken around mid-bit.
// Rejects false starts, flags framing errors (once per held-low line) and
// reports overrun when a byte completes while the single-entry buffer is full.
// Ports:
//   clk        core clock
//   rst        synchronous, active-high reset
//   serial_in  asynchronous RX line, idles high
//   rx_if      byte stream + error pulses (master side)
module uart_rx_oversampled #(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115_200
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          serial_in,
  uart_rx_oversampled_if.master         rx_if
);

  localparam int unsigned SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
  localparam int unsigned CNT_W            = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;

  if (SYMBOL_EDGE_TIME < 4) begin : g_rate_check
    $error("uart_rx_oversampled: CLOCK_FREQ/BAUD_RATE must be at least 4");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t             state, state_n;
  logic               sync1, rx_s;
  logic [CNT_W-1:0]   clk_cnt, clk_cnt_n;
  logic [2:0]         bit_cnt, bit_cnt_n;
  logic [1:0]         samp, samp_n;
  logic [7:0]         shreg, shreg_n;
  logic               byte_done;
  logic               fe_n;

  logic at_s0, at_s1, at_dec, bit_end, maj;

  assign at_s0   = (clk_cnt == CNT_W'(SAMPLE_TIME - 1));
  assign at_s1   = (clk_cnt == CNT_W'(SAMPLE_TIME));
  assign at_dec  = (clk_cnt == CNT_W'(SAMPLE_TIME + 1));
  assign bit_end = (clk_cnt == CNT_W'(SYMBOL_EDGE_TIME - 1));
  // Third vote is the live synchronized line at the decision point.
  assign maj = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= serial_in;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      samp    <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      clk_cnt <= clk_cnt_n;
      bit_cnt <= bit_cnt_n;
      samp    <= samp_n;
      shreg   <= shreg_n;
    end
  end

  always_comb begin
    state_n   = state;
    clk_cnt_n = clk_cnt;
    bit_cnt_n = bit_cnt;
    samp_n    = samp;
    shreg_n   = shreg;
    byte_done = 1'b0;
    fe_n      = 1'b0;

    if (state == START || state == DATA || state == STOP) begin
      clk_cnt_n = bit_end ? '0 : clk_cnt + 1'b1;
      if (at_s0) samp_n[0] = rx_s;
      if (at_s1) samp_n[1] = rx_s;
    end

    unique case (state)
      IDLE: begin
        clk_cnt_n = '0;
        bit_cnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        // With 4 clocks/bit the decision and the bit end coincide; a
        // false-start verdict must win over advancing to DATA.
        if (at_dec && maj) begin
          state_n = IDLE;
        end else if (bit_end) begin
          bit_cnt_n = '0;
          state_n   = DATA;
        end
      end
      DATA: begin
        if (at_dec) shreg_n[bit_cnt] = maj;
        if (bit_end) begin
          if (bit_cnt == 3'd7) state_n = STOP;
          else                 bit_cnt_n = bit_cnt + 1'b1;
        end
      end
      STOP: begin
        // Leave at the decision point so a following start bit that begins
        // right at the stop-bit end is not missed.
        if (at_dec) begin
          if (maj) begin
            byte_done = 1'b1;
            state_n   = IDLE;
          end else begin
            fe_n    = 1'b1;
            state_n = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_if.data_out       <= '0;
      rx_if.data_out_valid <= 1'b0;
      rx_if.frame_error    <= 1'b0;
      rx_if.overrun        <= 1'b0;
    end else begin
      rx_if.frame_error <= fe_n;
      rx_if.overrun     <= 1'b0;
      if (byte_done) begin
        if (!rx_if.data_out_valid || rx_if.data_out_ready) begin
          rx_if.data_out       <= shreg;
          rx_if.data_out_valid <= 1'b1;
        end else begin
          rx_if.overrun <= 1'b1;
        end
      end else if (rx_if.data_out_valid && rx_if.data_out_ready) begin
        rx_if.data_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled at 5 clocks per bit.
module tb_uart_rx_oversampled;

  localparam int SET = 5;   // 50 MHz / 10 Mbaud
  localparam int PER = 10;

  logic clk = 1'b0;
  logic rst;
  logic serial_in;

  uart_rx_oversampled_if rx_if ();

  uart_rx_oversampled #(
    .CLOCK_FREQ(50_000_000),
    .BAUD_RATE (10_000_000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .serial_in(serial_in),
    .rx_if    (rx_if.master)
  );

  always #(PER/2) clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: samples 1 time unit after each falling edge, i.e. the values the
  // next rising edge will see.
  logic [7:0] rx_q[$];
  int  n_rise  = 0;
  int  n_vhigh = 0;
  int  n_fe    = 0;
  int  n_ov    = 0;
  time rise_t  = 0;
  time start_t = 0;
  logic prev_v = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (rx_if.data_out_valid && !prev_v) begin
          n_rise++;
          rise_t = $time;
        end
        if (rx_if.data_out_valid) n_vhigh++;
        if (rx_if.data_out_valid && rx_if.data_out_ready) rx_q.push_back(rx_if.data_out);
        if (rx_if.frame_error) n_fe++;
        if (rx_if.overrun) n_ov++;
      end
      prev_v = rx_if.data_out_valid;
    end
  end

  // Caller is at a falling edge; returns at the falling edge where the stop
  // bit ends, so consecutive calls give exactly one stop bit time.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    serial_in = 1'b0;
    start_t   = $time;
    repeat (SET) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      repeat (SET) @(negedge clk);
    end
    serial_in = stop_bit;
    repeat (SET) @(negedge clk);
  endtask

  task automatic idle_bits(input int nbits);
    serial_in = 1'b1;
    repeat (nbits * SET) @(negedge clk);
  endtask

  initial begin
    #100_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int q0, r0, vh0, fe0, ov0;
    rst = 1'b1;
    serial_in = 1'b1;
    rx_if.data_out_ready = 1'b0;

    // Reset held 10 cycles with the line toggling.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      serial_in = ~serial_in;
    end
    @(negedge clk);
    serial_in = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_data",  rx_if.data_out, 8'h00);
    check_val("rst_valid", rx_if.data_out_valid, 1'b0);
    check_val("rst_fe",    rx_if.frame_error, 1'b0);
    check_val("rst_ov",    rx_if.overrun, 1'b0);
    @(negedge clk);

    // Reset in the middle of a frame, then a clean 0x41.
    rx_if.data_out_ready = 1'b1;
    q0 = rx_q.size(); r0 = n_rise;
    serial_in = 1'b0; repeat (SET) @(negedge clk);
    serial_in = 1'b1; repeat (SET) @(negedge clk);
    serial_in = 1'b0; repeat (SET) @(negedge clk);
    serial_in = 1'b1; repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle_bits(2);
    send_byte(8'h41, 1'b1);
    idle_bits(3);
    check_val("midrst_count", rx_q.size() - q0, 1);
    check_val("midrst_data",  rx_q[q0], 8'h41);
    check_val("midrst_rises", n_rise - r0, 1);

    // 0xA5 with ready high: one-cycle valid. Latency in cycles from the
    // start-bit drive: 2 sync + 1 detect + 48 in-frame + 1 register = 52.
    q0 = rx_q.size(); vh0 = n_vhigh;
    send_byte(8'hA5, 1'b1);
    idle_bits(3);
    check_val("a5_data",    rx_q[q0], 8'hA5);
    check_val("a5_vcycles", n_vhigh - vh0, 1);
    check_val("a5_latency", 32'((rise_t - start_t) / PER), 52);

    // Back-to-back frames with one stop bit each.
    q0 = rx_q.size(); fe0 = n_fe; ov0 = n_ov;
    send_byte(8'h61, 1'b1);
    send_byte(8'h62, 1'b1);
    send_byte(8'h63, 1'b1);
    idle_bits(3);
    check_val("b2b_count", rx_q.size() - q0, 3);
    check_val("b2b_0",     rx_q[q0],   8'h61);
    check_val("b2b_1",     rx_q[q0+1], 8'h62);
    check_val("b2b_2",     rx_q[q0+2], 8'h63);
    check_val("b2b_ov",    n_ov - ov0, 0);
    check_val("b2b_fe",    n_fe - fe0, 0);

    // Overrun: ready low, two bytes; second is dropped.
    rx_if.data_out_ready = 1'b0;
    q0 = rx_q.size(); ov0 = n_ov; r0 = n_rise;
    send_byte(8'h31, 1'b1);
    send_byte(8'h35, 1'b1);
    idle_bits(2);
    #1;
    check_val("ovr_valid", rx_if.data_out_valid, 1'b1);
    check_val("ovr_data",  rx_if.data_out, 8'h31);
    check_val("ovr_pulse", n_ov - ov0, 1);
    check_val("ovr_rises", n_rise - r0, 1);
    @(negedge clk);
    rx_if.data_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_val("ovr_drop_valid", rx_if.data_out_valid, 1'b0);
    check_val("ovr_count", rx_q.size() - q0, 1);
    check_val("ovr_first", rx_q[q0], 8'h31);
    @(negedge clk);
    idle_bits(2);

    // Framing error then a long break: one pulse, then recovery.
    q0 = rx_q.size(); fe0 = n_fe; r0 = n_rise;
    send_byte(8'h55, 1'b0);
    repeat (20 * SET) @(negedge clk);
    idle_bits(2);
    check_val("fe_pulses", n_fe - fe0, 1);
    check_val("fe_rises",  n_rise - r0, 0);
    send_byte(8'h3E, 1'b1);
    idle_bits(3);
    check_val("fe_recover_count", rx_q.size() - q0, 1);
    check_val("fe_recover_data",  rx_q[q0], 8'h3E);

    // 1-clock glitch and a 2-clock start bit are both false starts.
    fe0 = n_fe; ov0 = n_ov; r0 = n_rise;
    serial_in = 1'b0; @(negedge clk);
    idle_bits(3);
    serial_in = 1'b0; repeat (2) @(negedge clk);
    idle_bits(3);
    check_val("glitch_rises", n_rise - r0, 0);
    check_val("glitch_fe",    n_fe - fe0, 0);
    check_val("glitch_ov",    n_ov - ov0, 0);

    // Second byte completes in the very cycle the held byte is accepted:
    // decision cycle ends at the 51st rising edge after the start drive.
    rx_if.data_out_ready = 1'b0;
    q0 = rx_q.size(); ov0 = n_ov;
    send_byte(8'h70, 1'b1);
    fork
      send_byte(8'h71, 1'b1);
      begin
        repeat (51) @(negedge clk);
        rx_if.data_out_ready = 1'b1;
        @(negedge clk);
        rx_if.data_out_ready = 1'b0;
      end
    join
    #1;
    check_val("coinc_held",  rx_if.data_out, 8'h71);
    @(negedge clk);
    rx_if.data_out_ready = 1'b1;
    idle_bits(2);
    check_val("coinc_count", rx_q.size() - q0, 2);
    check_val("coinc_0",     rx_q[q0],   8'h70);
    check_val("coinc_1",     rx_q[q0+1], 8'h71);
    check_val("coinc_ov",    n_ov - ov0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
